// File: rtl/tick_serializer.sv
// Async-style frame serializer on clock1M, paced by a sampled divided rate clock.
// Frame: start bit, DATA_W data bits LSB first, optional even parity, STOP_BITS stop bits.
//
// state  | meaning
// IDLE   | line high, tx_ready asserted, waiting for a word
// ARM    | word captured, line high until the next rate tick
// START  | driving the start bit (0)
// DATA   | driving data bits, LSB first
// PARITY | driving the even-parity bit
// STOP   | driving stop bit(s) (1)
module tick_serializer #(
  parameter int DATA_W    = 8,
  parameter int PARITY_EN = 1,
  parameter int STOP_BITS = 1
) (
  input  logic              clock1M,
  input  logic              reset,
  input  logic              rate_clk,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              busy,
  output logic              frame_done
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] shift_reg;
  logic              parity_bit;
  logic [CNT_W-1:0]  bit_cnt;
  logic              sync_s1;
  logic              sync_s2;
  logic              sync_s3;
  logic              tick;
  logic              accept;

  // rate_clk is asynchronous data: synchronize, then edge-detect into a one-cycle tick
  always_ff @(posedge clock1M or negedge reset) begin
    if (!reset) begin
      sync_s1 <= 1'b0;
      sync_s2 <= 1'b0;
      sync_s3 <= 1'b0;
    end else begin
      sync_s1 <= rate_clk;
      sync_s2 <= sync_s1;
      sync_s3 <= sync_s2;
    end
  end

  assign tick   = sync_s2 & ~sync_s3;
  assign accept = tx_valid & tx_ready;

  always_ff @(posedge clock1M or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      bit_cnt    <= '0;
      tx_out     <= 1'b1;
      tx_ready   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          tx_out <= 1'b1;
          if (accept) begin
            shift_reg  <= tx_data;
            parity_bit <= ^tx_data;
            tx_ready   <= 1'b0;
            busy       <= 1'b1;
            state      <= ARM;
          end else begin
            tx_ready <= 1'b1;
          end
        end
        ARM: begin
          if (tick) begin
            tx_out <= 1'b0;
            state  <= START;
          end
        end
        START: begin
          if (tick) begin
            tx_out  <= shift_reg[0];
            bit_cnt <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            shift_reg <= shift_reg >> 1;
            if (bit_cnt == LAST_BIT) begin
              // counter is reused to count stop periods
              bit_cnt <= '0;
              if (PARITY_EN != 0) begin
                tx_out <= parity_bit;
                state  <= PARITY;
              end else begin
                tx_out <= 1'b1;
                state  <= STOP;
              end
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
              tx_out  <= shift_reg[1];
            end
          end
        end
        PARITY: begin
          if (tick) begin
            tx_out <= 1'b1;
            state  <= STOP;
          end
        end
        STOP: begin
          if (tick) begin
            if (bit_cnt == LAST_STOP) begin
              bit_cnt    <= '0;
              frame_done <= 1'b1;
              tx_ready   <= 1'b1;
              busy       <= 1'b0;
              state      <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          tx_out <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tick_serializer.sv
// Randomized bench for tick_serializer: two instances (parity/1 stop, no parity/2 stops)
// share stimulus and are checked against a bit-list frame model.
`timescale 1ns/1ps
module tb_tick_serializer;

  localparam int DW = 8;
  localparam int NB = 11;  // frame length in bit periods for both instances

  logic          clock1M = 1'b0;
  logic          reset = 1'b0;
  logic          rate_clk = 1'b0;
  logic          tx_valid = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic          tx_ready, tx_out, busy, frame_done;
  logic          tx_ready_np, tx_out_np, busy_np, frame_done_np;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int rate_half = 5;
  int rate_cnt = 0;
  bit rate_run = 1'b1;

  tick_serializer #(.DATA_W(DW), .PARITY_EN(1), .STOP_BITS(1)) dut (
    .clock1M(clock1M), .reset(reset), .rate_clk(rate_clk),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_out(tx_out), .busy(busy), .frame_done(frame_done)
  );

  tick_serializer #(.DATA_W(DW), .PARITY_EN(0), .STOP_BITS(2)) dut_np (
    .clock1M(clock1M), .reset(reset), .rate_clk(rate_clk),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready_np),
    .tx_out(tx_out_np), .busy(busy_np), .frame_done(frame_done_np)
  );

  initial forever #500 clock1M = ~clock1M;

  // rate clock with period 2*rate_half cycles; pausing it freezes the phase exactly
  initial forever begin
    @(posedge clock1M);
    cyc++;
    #100;
    if (rate_run) begin
      rate_cnt++;
      if (rate_cnt >= rate_half) begin
        rate_cnt = 0;
        rate_clk = ~rate_clk;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference frame: bit i of the line for word w
  function automatic int exp_bit(input logic [7:0] w, input int i, input bit pe);
    if (i == 0) return 0;
    if (i <= DW) return int'(w[i-1]);
    if (pe && i == DW + 1) return $countones(w) % 2;
    return 1;
  endfunction

  task automatic wait_ready();
    bit ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clock1M);
      if (tx_ready && tx_ready_np) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("ready_timeout", 32'(tx_ready), 1);
  endtask

  task automatic present(input logic [7:0] w, input bit keep);
    wait_ready();
    tx_data  = w;
    tx_valid = 1'b1;
    @(negedge clock1M);
    check("accept_ready_drop", 32'(tx_ready), 0);
    check("accept_busy", 32'(busy), 1);
    if (!keep) begin
      tx_valid = 1'b0;
      tx_data  = 8'($urandom);
    end
  endtask

  task automatic find_start(output bit found, output int start_cyc);
    int p = 2 * rate_half;
    found = 1'b0;
    start_cyc = 0;
    for (int i = 0; i < 20 * p + 20; i++) begin
      @(negedge clock1M);
      if (tx_out == 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    check("start_seen", 32'(tx_out), 0);
    check("start_seen_np", 32'(tx_out_np), 0);
    start_cyc = cyc;
  endtask

  task automatic watch_frame(input logic [7:0] w, input bit b2b, input int stall_bit,
                             output int start_cyc);
    int p = 2 * rate_half;
    bit found;
    find_start(found, start_cyc);
    if (!found) return;
    for (int k = 0; k <= NB * p + 1; k++) begin
      if (k > 0) @(negedge clock1M);
      if (k % p == p / 2) begin
        check($sformatf("bit%0d_w%02h", k / p, w), 32'(tx_out), 32'(exp_bit(w, k / p, 1'b1)));
        check($sformatf("np_bit%0d_w%02h", k / p, w), 32'(tx_out_np), 32'(exp_bit(w, k / p, 1'b0)));
        if (stall_bit == k / p) begin
          rate_run = 1'b0;
          for (int s = 0; s < 3 * p; s++) begin
            @(negedge clock1M);
            check("stall_hold", 32'(tx_out), 32'(exp_bit(w, k / p, 1'b1)));
          end
          check("stall_busy", 32'(busy), 1);
          rate_run = 1'b1;
        end
      end
      if (k == NB * p - 1) begin
        check("done_early", 32'(frame_done), 0);
        check("done_early_np", 32'(frame_done_np), 0);
      end
      if (k == NB * p) begin
        check("done_pulse", 32'(frame_done), 1);
        check("done_pulse_np", 32'(frame_done_np), 1);
        check("ready_after_done", 32'(tx_ready), 1);
      end
      if (k == NB * p + 1) begin
        check("done_width", 32'(frame_done), 0);
        check("done_width_np", 32'(frame_done_np), 0);
        check("b2b_accept_ready", 32'(tx_ready), b2b ? 0 : 1);
        check("b2b_accept_busy", 32'(busy), b2b ? 1 : 0);
        if (b2b) begin
          tx_valid = 1'b0;
          tx_data  = 8'($urandom);
        end
      end
      if (!b2b && (k % 7 == 3)) tx_data = 8'($urandom);
    end
  endtask

  task automatic reset_mid(input logic [7:0] w, input int bit_idx);
    int p = 2 * rate_half;
    int sc;
    int bad = 0;
    bit found;
    present(w, 1'b0);
    find_start(found, sc);
    if (!found) return;
    repeat (bit_idx * p + p / 2) @(negedge clock1M);
    check("pre_reset_bit", 32'(tx_out), 32'(exp_bit(w, bit_idx, 1'b1)));
    reset = 1'b0;
    #1;
    check("rst_tx_out", 32'(tx_out), 1);
    check("rst_tx_out_np", 32'(tx_out_np), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'(tx_ready), 0);
    check("rst_done", 32'(frame_done), 0);
    repeat (3) @(negedge clock1M);
    reset = 1'b1;
    @(negedge clock1M);
    check("rel_ready", 32'(tx_ready), 1);
    check("rel_busy", 32'(busy_np), 0);
    for (int i = 0; i < NB * p; i++) begin
      @(negedge clock1M);
      if (frame_done !== 1'b0 || frame_done_np !== 1'b0 || tx_out !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("abandoned_quiet", 32'(bad), 0);
  endtask

  initial begin
    int s1, s2, bad;
    logic [7:0] w;

    // reset held, then released
    for (int i = 0; i < 5; i++) begin
      @(negedge clock1M);
      check("rst_hold_tx_out", 32'(tx_out), 1);
      check("rst_hold_busy", 32'(busy), 0);
      check("rst_hold_ready", 32'(tx_ready), 0);
    end
    reset = 1'b1;
    @(negedge clock1M);
    check("ready_after_release", 32'(tx_ready), 1);
    check("ready_after_release_np", 32'(tx_ready_np), 1);
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock1M);
      if (tx_out !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) bad++;
    end
    check("idle_quiet", 32'(bad), 0);

    // directed words at 10 cycles per bit
    present(8'hA5, 1'b0);
    watch_frame(8'hA5, 1'b0, -1, s1);
    present(8'h07, 1'b0);
    watch_frame(8'h07, 1'b0, -1, s1);

    // back-to-back with tx_valid held high and data changed after accept
    present(8'h00, 1'b1);
    tx_data = 8'hFF;
    watch_frame(8'h00, 1'b1, -1, s1);
    watch_frame(8'hFF, 1'b0, -1, s2);
    check("b2b_start_gap", 32'(s2 - s1), 32'((NB + 1) * 10));

    // stalled rate clock at 10 cycles per bit
    present(8'hC3, 1'b0);
    watch_frame(8'hC3, 1'b0, 3, s1);

    // random words at random rate periods
    for (int n = 0; n < 12; n++) begin
      rate_half = $urandom_range(3, 8);
      w = 8'($urandom);
      present(w, 1'b0);
      watch_frame(w, 1'b0, (n % 4 == 0) ? int'($urandom_range(0, NB - 1)) : -1, s1);
    end

    // reset mid-frame, then a fresh frame
    rate_half = 5;
    reset_mid(8'h3C, 4);
    reset_mid(8'h3C, 0);
    present(8'h3C, 1'b0);
    watch_frame(8'h3C, 1'b0, -1, s1);

    // 100 cycles per bit, with one stall
    rate_half = 50;
    w = 8'($urandom);
    present(w, 1'b0);
    watch_frame(w, 1'b0, 5, s1);
    present(8'h5A, 1'b0);
    watch_frame(8'h5A, 1'b0, -1, s1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tick_serializer.md
Name: tick_serializer

Overview:
- Frame serializer running on the 1 MHz system clock.
- Paced by a divided rate clock from the clock divider, normally clk_100KHz, which gives 10 clock1M cycles per bit.
- Accepts parallel words over a valid/ready handshake and drives one async-style serial line: start bit, data LSB first, optional even parity, stop bits.
- Sits directly downstream of the divider; the rate input is treated as data and is never used as a clock.

Parameters:
- DATA_W, 8, data bits per frame (≥2).
- PARITY_EN, 1, 1 inserts an even-parity bit after the data; 0 omits it.
- STOP_BITS, 1, number of stop-bit periods (1 or 2).

Ports:
- clock1M  input  1  system clock, 1 MHz; the only clock in the block.
- reset  input  1  asynchronous, active-low reset (block in reset while 0).
- rate_clk  input  1  divided rate clock (clk_100KHz or clk_10KHz); sampled, never used as a clock.
- tx_data  input  DATA_W  word to send; captured on accept.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  block can accept a word.
- tx_out  output  1  serial line; idles high.
- busy  output  1  a frame is armed or in progress.
- frame_done  output  1  one-cycle pulse when the last stop bit ends.

Behaviour:
- Reset (reset=0, async):
  - tx_out=1, tx_ready=0, busy=0, frame_done=0.
  - FSM=IDLE; shift register, bit counter and synchronizer flops all 0.
  - tx_ready rises at the first clock1M edge after reset returns to 1.
- Rate sampling:
  - rate_clk goes through a 2-flop synchronizer (s1, s2) plus a history flop s3.
  - tick = s2 & ~s3 is a one-cycle pulse per rate_clk rising edge, 2-3 cycles after that edge.
  - A tick produced at reset release (rate_clk already high) is harmless because IDLE ignores ticks.
- Handshake:
  - Accept when tx_valid & tx_ready at a clock1M edge.
  - tx_ready is registered: 1 only in IDLE, and it drops in the cycle after accept.
  - On accept:
    - tx_data is captured into the shift register.
    - Parity = XOR of tx_data is captured.
    - FSM goes to ARM.
  - tx_valid while tx_ready=0 is ignored; the word is not queued.
  - tx_data changes after accept do not affect the frame.
- FSM (transitions only on tick, except the accept out of IDLE):
  - IDLE: tx_out=1. Accept → ARM.
  - ARM: tx_out=1. Tick → START, tx_out←0.
  - START: tick → DATA, tx_out←shift[0], bit counter←0.
  - DATA: on each tick:
    - Shift right and increment the counter.
    - After DATA_W bits have been sent: → PARITY (PARITY_EN=1) with tx_out←parity, else → STOP with tx_out←1.
  - PARITY: tick → STOP, tx_out←1.
  - STOP: held for STOP_BITS ticks. At the final tick: → IDLE, frame_done=1 for that one cycle, tx_ready←1.
- Timing rules:
  - Every bit lasts exactly one rate period (tick to tick).
  - tx_out changes at the clock1M edge that ends the tick cycle.
  - Frame length = 1 + DATA_W + PARITY_EN + STOP_BITS bit periods.
  - Minimum gap between frames: ARM waits for the next tick after accept, so the line stays high at least one extra bit period after the stop bit(s).
- busy = FSM≠IDLE, registered alongside the state.
- Bit counter width: $clog2(DATA_W+1). Counter values never reach past DATA_W.
- rate_clk stuck (no ticks): the FSM holds its current state and tx_out holds its value indefinitely; no timeout.
- Reset mid-frame: tx_out returns to 1 immediately (async) and the frame is abandoned. There is no partial resume; the word is lost.

Test Plan:
- Reset then release, rate_clk=100 kHz square wave:
  - tx_out=1, busy=0 throughout reset.
  - tx_ready=1 one cycle after release.
  - No tx_out activity for 200 cycles.
- Send 0xA5, PARITY_EN=1, STOP_BITS=1, 100 kHz rate:
  - tx_out sequence at 10 cycles/bit: 0 | 1,0,1,0,0,1,0,1 | 0 | 1.
  - 110 cycles from the start-bit edge to frame_done.
  - frame_done is exactly one cycle wide.
- Send 0x07 with PARITY_EN=1: parity bit = 1 (odd popcount). Same word with PARITY_EN=0: 10-bit frame, no parity slot.
- Back-to-back 0x00 then 0xFF, tx_valid held high:
  - Second accept occurs exactly one cycle after the first frame_done.
  - Line stays high for ≥1 bit period between the stop bit and the second start bit.
  - Changing tx_data mid-frame does not corrupt either frame.
- Pull reset low during DATA bit 3 of 0x3C:
  - tx_out=1 in the same cycle.
  - busy=0; no frame_done.
  - After release, a fresh 0x3C frame is sent correctly.
- rate_clk = 10 kHz (clk_10KHz): each bit is 100 cycles. Stop rate_clk mid-frame: tx_out holds its level and resumes on the next tick.
